psdsqrt_frac: RTL and testbench

Parametrised, self-timed sequential square-root unit with a fixed-point fractional result, optional round-to-nearest, an exactness flag and a valid/ready handshake on both sides. It computes one result bit per clock using a multiplier-free digit-by-digit restoring algorithm. It sits in the datapath wherever `sqrt` of an unsigned integer is needed with sub-integer precision. There is no external stop pulse: the unit reports completion itself.

---
 rtl/psdsqrt_frac.sv | 189 ++++++++++++++++++
 tb/tb_psdsqrt_frac.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psdsqrt_frac.sv
// psdsqrt_frac: sequential square root of an unsigned integer with a
// fixed-point fractional result. One result bit per clock is produced by the
// digit-by-digit restoring method, with optional round-to-nearest and an
// exactness flag. Valid/ready handshake on operand and result.
module psdsqrt_frac #(
    parameter int NBITSIN  = 32,
    parameter int FRACBITS = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NBITSIN-1:0]            xin,
    input  logic                          round_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NBITSIN/2+FRACBITS-1:0] sqrt,
    output logic                          exact
);

    // Radicand width, result width, stored remainder width, counter width.
    localparam int W   = NBITSIN + 2*FRACBITS;
    localparam int RW  = NBITSIN/2 + FRACBITS;
    localparam int RMW = RW + 2;
    localparam int CW  = $clog2(RW + 2);

    // Reject unsupported parameter combinations at elaboration.
    generate
        if (((NBITSIN % 2) != 0) || (NBITSIN < 4) || (NBITSIN > 64)) begin : g_bad_nbitsin
            $error("psdsqrt_frac: NBITSIN must be even and within 4..64");
        end
        if ((FRACBITS < 0) || (FRACBITS > 32)) begin : g_bad_fracbits
            $error("psdsqrt_frac: FRACBITS must be within 0..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    rad_reg;
    logic [RW:0]     root_reg;
    logic [RMW-1:0]  rem_reg;
    logic [CW-1:0]   cnt_reg;
    logic            rnd_reg;
    logic [RW-1:0]   sqrt_reg;
    logic            exact_reg;

    logic            accept;
    logic [RMW+1:0]  rem_shift;
    logic [RMW+1:0]  trial;
    logic [RMW+1:0]  rem_diff;
    logic            take;
    logic [RMW-1:0]  rem_step;
    logic [RW:0]     root_step;
    logic            unused_rem_top;

    logic [CW-1:0]   iter_last;
    logic            last_step;
    logic            half;
    logic [RW:0]     rounded;
    logic [RW-1:0]   sqrt_fin;
    logic            exact_fin;

    assign accept = in_valid & in_ready;

    // One restoring iteration: bring down two radicand bits, compare against
    // the trial divisor (root<<2)|1, subtract and shift the decision into root.
    // The compare runs two bits wider than the stored remainder so it can never
    // wrap; the committed remainder is bounded by 2*root and fits in RW+2 bits.
    always_comb begin
        rem_shift = {rem_reg, rad_reg[W-1 -: 2]};
        trial     = {1'b0, root_reg, 2'b01};
        take      = (rem_shift >= trial);
        rem_diff  = take ? (rem_shift - trial) : rem_shift;
        rem_step  = rem_diff[RMW-1:0];
        root_step = {root_reg[RW-1:0], take};
    end

    // The top compare bits are always zero after the subtraction.
    assign unused_rem_top = ^rem_diff[RMW+1:RMW];

    // Result formation for the iteration that finishes the operation. With
    // rounding the extra iteration supplies the half bit; a carry out of RW
    // bits saturates the result instead of wrapping to zero.
    always_comb begin
        iter_last = rnd_reg ? CW'(RW) : CW'(RW - 1);
        last_step = (cnt_reg == iter_last);
        half      = root_step[0];
        rounded   = {1'b0, root_step[RW:1]} + {{RW{1'b0}}, 1'b1};
        if (rnd_reg) begin
            if (half) begin
                sqrt_fin = rounded[RW] ? {RW{1'b1}} : rounded[RW-1:0];
            end else begin
                sqrt_fin = root_step[RW:1];
            end
            exact_fin = (rem_step == '0) && !half;
        end else begin
            sqrt_fin  = root_step[RW-1:0];
            exact_fin = (rem_step == '0);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides every other request.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (clear) begin
                    state_next = S_IDLE;
                end else if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (clear || out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_reg == S_IDLE) & ~clear;
        out_valid = (state_reg == S_DONE);
    end

    // Iteration datapath: load on accept, step once per cycle while computing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rad_reg  <= '0;
            root_reg <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            rnd_reg  <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (accept) begin
                rad_reg  <= W'(xin) << (2*FRACBITS);
                root_reg <= '0;
                rem_reg  <= '0;
                cnt_reg  <= '0;
                rnd_reg  <= round_en;
            end
        end else if (state_reg == S_CALC) begin
            rad_reg  <= {rad_reg[W-3:0], 2'b00};
            root_reg <= root_step;
            rem_reg  <= rem_step;
            cnt_reg  <= cnt_reg + CW'(1);
        end
    end

    // Result registers: written only when a computation completes uncleared,
    // held otherwise (including across a clear in DONE).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sqrt_reg  <= '0;
            exact_reg <= 1'b0;
        end else if ((state_reg == S_CALC) && !clear && last_step) begin
            sqrt_reg  <= sqrt_fin;
            exact_reg <= exact_fin;
        end
    end

    assign sqrt  = sqrt_reg;
    assign exact = exact_reg;

endmodule

// File: tb/tb_psdsqrt_frac.sv
// Testbench for psdsqrt_frac: table-driven vectors on the default
// configuration, hand-written handshake/clear/reset sequences, and a
// reference-model sweep on the smallest and largest configurations.
`timescale 1ns/1ps
module tb_psdsqrt_frac;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Default configuration (32, 8)
    logic        clear, in_valid, in_ready, round_en, out_valid, out_ready, exact;
    logic [31:0] xin;
    logic [23:0] sqrt;

    // Small configuration (4, 0)
    logic        s_clear, s_in_valid, s_in_ready, s_round_en, s_out_valid, s_out_ready, s_exact;
    logic [3:0]  s_xin;
    logic [1:0]  s_sqrt;

    // Large configuration (64, 32)
    logic        b_clear, b_in_valid, b_in_ready, b_round_en, b_out_valid, b_out_ready, b_exact;
    logic [63:0] b_xin;
    logic [63:0] b_sqrt;

    psdsqrt_frac #(.NBITSIN(32), .FRACBITS(8)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .xin(xin), .round_en(round_en),
        .out_valid(out_valid), .out_ready(out_ready), .sqrt(sqrt), .exact(exact)
    );

    psdsqrt_frac #(.NBITSIN(4), .FRACBITS(0)) dut_small (
        .clock(clock), .reset(reset), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .xin(s_xin), .round_en(s_round_en),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .sqrt(s_sqrt), .exact(s_exact)
    );

    psdsqrt_frac #(.NBITSIN(64), .FRACBITS(32)) dut_big (
        .clock(clock), .reset(reset), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .xin(b_xin), .round_en(b_round_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sqrt(b_sqrt), .exact(b_exact)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] x;
        logic        rnd;
        logic [23:0] q;
        logic        ex;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Integer square root by greedy bit setting with a squaring test.
    function automatic logic [65:0] isqrt(input logic [131:0] x);
        logic [65:0]  r;
        logic [65:0]  t;
        logic [131:0] sq;
        r = '0;
        for (int b = 65; b >= 0; b--) begin
            t  = r | (66'd1 << b);
            sq = {66'd0, t} * {66'd0, t};
            if (sq <= x) r = t;
        end
        return r;
    endfunction

    // Expected result for a scaled radicand xs = x * 4^FRACBITS.
    task automatic model_ref(input logic [131:0] xs, input int rw, input logic rnd,
                             output logic [127:0] q, output logic ex);
        logic [131:0] fl, s2, rv, maxv, res;
        fl   = 132'(isqrt(xs));
        s2   = 132'(isqrt(xs << 2));
        rv   = (s2 + 132'd1) >> 1;
        maxv = (132'd1 << rw) - 132'd1;
        res  = rnd ? ((rv > maxv) ? maxv : rv) : fl;
        q    = res[127:0];
        ex   = ((fl * fl) == xs);
    endtask

    task automatic start_main(input logic [31:0] x, input logic r);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("in_ready_before_start", 128'(in_ready), 128'(1));
        xin = x; round_en = r; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; xin = '0; round_en = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid is seen.
    task automatic wait_main(output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic run_main(input logic [31:0] x, input logic r, input logic [23:0] q,
                            input logic ex, input int elat);
        int lat;
        start_main(x, r);
        chk("busy_in_ready", 128'(in_ready), 128'(0));
        wait_main(lat);
        chk("sqrt", 128'(sqrt), 128'(q));
        chk("exact", 128'(exact), 128'(ex));
        chk("latency", 128'(lat), 128'(elat));
        $display("main x=0x%08h rnd=%0d sqrt=0x%06h exact=%0d lat=%0d", x, r, sqrt, exact, lat);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("post_out_valid", 128'(out_valid), 128'(0));
        chk("post_in_ready", 128'(in_ready), 128'(1));
    endtask

    task automatic run_small(input logic [3:0] x, input logic r);
        logic [127:0] q;
        logic         ex;
        int           n;
        model_ref(132'(x), 2, r, q, ex);
        chk("small_in_ready", 128'(s_in_ready), 128'(1));
        s_xin = x; s_round_en = r; s_in_valid = 1'b1;
        @(posedge clock); #1;
        s_in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!s_out_valid && n < 100);
        chk("small_sqrt", 128'(s_sqrt), q);
        chk("small_exact", 128'(s_exact), 128'(ex));
        chk("small_latency", 128'(n), 128'(r ? 3 : 2));
        $display("small x=%0d rnd=%0d sqrt=%0d exact=%0d lat=%0d", x, r, s_sqrt, s_exact, n);
        s_out_ready = 1'b1;
        @(posedge clock); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic run_big(input logic [63:0] x, input logic r);
        logic [127:0] q;
        logic         ex;
        int           n;
        model_ref({4'd0, x, 64'd0}, 64, r, q, ex);
        chk("big_in_ready", 128'(b_in_ready), 128'(1));
        b_xin = x; b_round_en = r; b_in_valid = 1'b1;
        @(posedge clock); #1;
        b_in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!b_out_valid && n < 200);
        chk("big_sqrt", 128'(b_sqrt), q);
        chk("big_exact", 128'(b_exact), 128'(ex));
        chk("big_latency", 128'(n), 128'(r ? 65 : 64));
        $display("big x=0x%016h rnd=%0d sqrt=0x%016h exact=%0d lat=%0d", x, r, b_sqrt, b_exact, n);
        b_out_ready = 1'b1;
        @(posedge clock); #1;
        b_out_ready = 1'b0;
    endtask

    // Hard stop in case a sequence stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          cnt;
        logic [63:0] big_list [7];

        vecs[0]  = '{32'd144,        1'b0, 24'hC00,    1'b1, 24};
        vecs[1]  = '{32'd0,          1'b0, 24'h000,    1'b1, 24};
        vecs[2]  = '{32'd10,         1'b0, 24'h329,    1'b0, 24};
        vecs[3]  = '{32'd10,         1'b1, 24'h32A,    1'b0, 25};
        vecs[4]  = '{32'hFFFFFFFF,   1'b0, 24'hFFFFFF, 1'b0, 24};
        vecs[5]  = '{32'hFFFFFFFF,   1'b1, 24'hFFFFFF, 1'b0, 25};
        vecs[6]  = '{32'hFFFE0001,   1'b0, 24'hFFFF00, 1'b1, 24};
        vecs[7]  = '{32'hFFFE0001,   1'b1, 24'hFFFF00, 1'b1, 25};
        vecs[8]  = '{32'd144,        1'b1, 24'hC00,    1'b1, 25};
        vecs[9]  = '{32'd2,          1'b0, 24'h16A,    1'b0, 24};
        vecs[10] = '{32'd1,          1'b1, 24'h100,    1'b1, 25};
        vecs[11] = '{32'd3,          1'b1, 24'h1BB,    1'b0, 25};
        vecs[12] = '{32'd5,          1'b0, 24'h23C,    1'b0, 24};
        vecs[13] = '{32'h40000000,   1'b1, 24'h800000, 1'b1, 25};

        big_list[0] = 64'd0;
        big_list[1] = 64'd1;
        big_list[2] = 64'hFFFFFFFFFFFFFFFF;
        big_list[3] = 64'hFFFFFFFE00000001;
        big_list[4] = 64'h4000000000000000;
        big_list[5] = 64'd152399025;
        big_list[6] = 64'd2;

        reset = 1'b0;
        clear = 1'b0; in_valid = 1'b0; round_en = 1'b0; out_ready = 1'b0; xin = '0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_round_en = 1'b0; s_out_ready = 1'b0; s_xin = '0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_round_en = 1'b0; b_out_ready = 1'b0; b_xin = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_sqrt", 128'(sqrt), 128'(0));
        chk("reset_exact", 128'(exact), 128'(0));
        chk("reset_small_out_valid", 128'(s_out_valid), 128'(0));
        chk("reset_big_sqrt", 128'(b_sqrt), 128'(0));
        reset = 1'b1;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(1));

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            run_main(vecs[i].x, vecs[i].rnd, vecs[i].q, vecs[i].ex, vecs[i].lat);
        end

        // Back-pressure: result held for 10 cycles, in_valid pulses ignored
        start_main(32'd10, 1'b0);
        wait_main(lat);
        chk("bp_latency", 128'(lat), 128'(24));
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2) == 0;
            xin      = 32'd144;
            @(posedge clock); #1;
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_sqrt", 128'(sqrt), 128'(24'h329));
            chk("bp_exact", 128'(exact), 128'(0));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0; xin = '0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        cnt = 0;
        repeat (30) begin
            @(posedge clock); #1;
            if (out_valid) cnt++;
        end
        chk("bp_single_transfer", 128'(cnt), 128'(0));
        $display("seq back-pressure done sqrt=0x%06h", sqrt);

        // clear during CALC discards the operand
        start_main(32'd12345, 1'b0);
        repeat (5) begin
            @(posedge clock); #1;
        end
        clear = 1'b1;
        #1;
        chk("clr_calc_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        chk("clr_calc_in_ready", 128'(in_ready), 128'(1));
        cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) cnt++;
        end
        chk("clr_calc_no_valid", 128'(cnt), 128'(0));
        chk("clr_calc_sqrt_kept", 128'(sqrt), 128'(24'h329));
        $display("seq clear-in-calc done");
        run_main(32'd144, 1'b0, 24'hC00, 1'b1, 24);

        // clear during DONE drops out_valid but keeps the result registers
        start_main(32'd10, 1'b1);
        wait_main(lat);
        chk("clr_done_latency", 128'(lat), 128'(25));
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; out_ready = 1'b0;
        #1;
        chk("clr_done_out_valid", 128'(out_valid), 128'(0));
        chk("clr_done_sqrt", 128'(sqrt), 128'(24'h32A));
        chk("clr_done_exact", 128'(exact), 128'(0));
        chk("clr_done_in_ready", 128'(in_ready), 128'(1));
        $display("seq clear-in-done done sqrt=0x%06h", sqrt);

        // clear wins over in_valid in IDLE
        clear = 1'b1; in_valid = 1'b1; xin = 32'd144;
        #1;
        chk("clr_idle_in_ready", 128'(in_ready), 128'(0));
        @(posedge clock); #1;
        clear = 1'b0; in_valid = 1'b0; xin = '0;
        #1;
        chk("clr_idle_still_idle", 128'(in_ready), 128'(1));
        $display("seq clear-vs-in_valid done");

        // Asynchronous reset mid-CALC
        start_main(32'd144, 1'b0);
        repeat (5) begin
            @(posedge clock); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_sqrt", 128'(sqrt), 128'(0));
        chk("rst_mid_exact", 128'(exact), 128'(0));
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
        $display("seq reset-mid-calc done");
        run_main(32'd144, 1'b0, 24'hC00, 1'b1, 24);

        // Parameter sweep: small configuration exhaustively
        for (int x = 0; x < 16; x++) begin
            run_small(4'(x), 1'b0);
            run_small(4'(x), 1'b1);
        end

        // Parameter sweep: large configuration, boundaries and random operands
        for (int i = 0; i < 7; i++) begin
            run_big(big_list[i], 1'b0);
            run_big(big_list[i], 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            logic [63:0] rx;
            rx = {$urandom(), $urandom()};
            run_big(rx, 1'b0);
            run_big(rx, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
